mul_share_arbiter: RTL

Shares one combinational `booth_wallace_cla` 16x16 signed multiplier among `NREQ` requesters. Requests arrive on per-requester valid/ready ports. Each cycle the block grants at most one request, drives the granted operands into the multiplier, and registers the 32-bit product, with the requester ID, into a single output stage that is flow-controlled by `rsp_ready`. It sits between the datapath clients and the multiplier, so that only one multiplier instance is needed.

---
 rtl/mul_share_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mul_share_arbiter.sv
// Shares one combinational 16x16 signed Booth/Wallace/CLA multiplier among NREQ requesters.
// Define MUL_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).

module booth_wallace_cla (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);
  logic [7:0][31:0] pp;
  logic [16:0]      bx;
  logic [31:0]      a_ext;
  logic [31:0]      s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

  function automatic logic [63:0] csa(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    logic [31:0] sum, cy;
    sum = x ^ y ^ z;
    cy  = ((x & y) | (x & z) | (y & z)) << 1;
    return {cy, sum};
  endfunction

  // 4-bit lookahead groups; the group carry feeds the next group.
  function automatic logic [31:0] cla32(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] g, pr, sum;
    logic [32:0] c;
    g    = x & y;
    pr   = x ^ y;
    c    = '0;
    for (int k = 0; k < 8; k++) begin
      c[4*k+1] = g[4*k] | (pr[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (pr[4*k+1] & g[4*k]) | (pr[4*k+1] & pr[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (pr[4*k+2] & g[4*k+1]) | (pr[4*k+2] & pr[4*k+1] & g[4*k])
               | (pr[4*k+2] & pr[4*k+1] & pr[4*k] & c[4*k]);
      c[4*k+4] = g[4*k+3] | (pr[4*k+3] & g[4*k+2]) | (pr[4*k+3] & pr[4*k+2] & g[4*k+1])
               | (pr[4*k+3] & pr[4*k+2] & pr[4*k+1] & g[4*k])
               | (pr[4*k+3] & pr[4*k+2] & pr[4*k+1] & pr[4*k] & c[4*k]);
    end
    sum = pr ^ c[31:0];
    return sum;
  endfunction

  // Radix-4 Booth: eight sign-extended partial products, summed modulo 2^32.
  always_comb begin
    bx    = {b, 1'b0};
    a_ext = {{16{a[15]}}, a};
    pp    = '0;
    for (int i = 0; i < 8; i++) begin
      case (bx[2*i +: 3])
        3'b001, 3'b010: pp[i] = a_ext;
        3'b011:         pp[i] = a_ext << 1;
        3'b100:         pp[i] = -(a_ext << 1);
        3'b101, 3'b110: pp[i] = -a_ext;
        default:        pp[i] = '0;
      endcase
      pp[i] = pp[i] << (2*i);
    end
  end

  always_comb begin
    {c0, s0} = csa(pp[0], pp[1], pp[2]);
    {c1, s1} = csa(pp[3], pp[4], pp[5]);
    {c2, s2} = csa(s0, c0, s1);
    {c3, s3} = csa(c1, pp[6], pp[7]);
    {c4, s4} = csa(s2, c2, s3);
    {c5, s5} = csa(s4, c4, c3);
    p        = cla32(s5, c5);
  end
endmodule

module mul_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_product,
  output logic [15:0]          op_count
);
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [31:0]     rsp_product_q, rsp_product_d;
  logic [15:0]     op_count_q, op_count_d;
  logic            stage_free, gnt_found, xfer;
  logic [IDW-1:0]  gnt_id;
  logic [15:0]     mul_a, mul_b;
  logic [31:0]     mul_p;

`ifdef MUL_ARB_RR_EN
  logic [IDW-1:0]  ptr_q, ptr_d;

  // Search upward from ptr, wrapping modulo NREQ (NREQ need not be a power of two).
  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (req_valid[k]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(k);
      end
    end
  end
`endif

  always_comb begin
    stage_free = !rsp_valid_q || rsp_ready;
    xfer       = gnt_found && stage_free && !rst;
    req_ready  = '0;
    if (xfer) req_ready[gnt_id] = 1'b1;
    mul_a      = req_a[16*gnt_id +: 16];
    mul_b      = req_b[16*gnt_id +: 16];
  end

  booth_wallace_cla u_mul (.a(mul_a), .b(mul_b), .p(mul_p));

  always_comb begin
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_product_d = rsp_product_q;
    op_count_d    = op_count_q;
    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
      op_count_d  = op_count_q + 16'd1;
    end
    if (xfer) begin
      rsp_valid_d   = 1'b1;
      rsp_id_d      = gnt_id;
      rsp_product_d = mul_p;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
      op_count_q    <= '0;
    end else begin
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_product_q <= rsp_product_d;
      op_count_q    <= op_count_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_product = rsp_product_q;
  assign op_count    = op_count_q;
endmodule
